// File: rtl/hs32_ahb_arb.sv
// Two-master AHB-lite arbiter. m0 (LSU) and m1 (instruction fetch) share one slave bus.
// One master's address phase overlaps the other's data phase, and m1 starvation is bounded.
module hs32_ahb_arb #(
    parameter int MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_HADDR_i,
    input  logic [1:0]  m0_HTRANS_i,
    input  logic        m0_HWRITE_i,
    input  logic [2:0]  m0_HSIZE_i,
    input  logic [31:0] m0_HWDATA_i,
    output logic        m0_HREADY_o,
    output logic        m0_HRESP_o,
    output logic [31:0] m0_HRDATA_o,
    input  logic [31:0] m1_HADDR_i,
    input  logic [1:0]  m1_HTRANS_i,
    input  logic        m1_HWRITE_i,
    input  logic [2:0]  m1_HSIZE_i,
    input  logic [31:0] m1_HWDATA_i,
    output logic        m1_HREADY_o,
    output logic        m1_HRESP_o,
    output logic [31:0] m1_HRDATA_o,
    output logic [31:0] HADDR_o,
    output logic        HWRITE_o,
    output logic [2:0]  HSIZE_o,
    output logic [1:0]  HTRANS_o,
    output logic [31:0] HWDATA_o,
    input  logic        HREADY_i,
    input  logic        HRESP_i,
    input  logic [31:0] HRDATA_i
);
    localparam int SW = $clog2(MAX_STARVE + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_DATA = 2'b10
    } mst_state_e;

    mst_state_e    st_r     [2];
    logic [31:0]   haddr_r  [2];
    logic          hwrite_r [2];
    logic [2:0]    hsize_r  [2];
    logic          lock_r;
    logic          lock_id_r;
    logic          owner_valid_r;
    logic          owner_id_r;
    logic [SW-1:0] starve_r;

    logic [1:0]    req_s;
    logic [1:0]    ready_s;
    logic [1:0]    pend_s;
    logic [1:0]    capture_s;
    logic          grant_valid_s;
    logic          grant_id_s;
    logic          accept_s;
    logic [31:0]   addr_in_s  [2];
    logic          write_in_s [2];
    logic [2:0]    size_in_s  [2];

    function automatic logic is_request(input logic [1:0] htrans);
        return (htrans == 2'b10) || (htrans == 2'b11);
    endfunction

    assign addr_in_s[0]  = m0_HADDR_i;
    assign addr_in_s[1]  = m1_HADDR_i;
    assign write_in_s[0] = m0_HWRITE_i;
    assign write_in_s[1] = m1_HWRITE_i;
    assign size_in_s[0]  = m0_HSIZE_i;
    assign size_in_s[1]  = m1_HSIZE_i;
    assign req_s         = {is_request(m1_HTRANS_i), is_request(m0_HTRANS_i)};

    // Per-master ready strobe, pending flag and capture decode
    always_comb begin
        ready_s = 2'b00;
        pend_s  = 2'b00;
        for (int n = 0; n < 2; n++) begin
            case (st_r[n])
                ST_IDLE: ready_s[n] = 1'b1;
                ST_PEND: pend_s[n]  = 1'b1;
                ST_DATA: ready_s[n] = HREADY_i;
                default: ready_s[n] = 1'b0;
            endcase
        end
        capture_s = ready_s & req_s;
    end

    // Grant selection: a locked presentation wins, otherwise priority with starvation override
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (lock_r) begin
            grant_valid_s = 1'b1;
            grant_id_s    = lock_id_r;
        end else if (pend_s == 2'b11) begin
            grant_valid_s = 1'b1;
            grant_id_s    = (starve_r == STARVE_MAX);
        end else if (pend_s != 2'b00) begin
            grant_valid_s = 1'b1;
            grant_id_s    = pend_s[1];
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
        accept_s = grant_valid_s & HREADY_i;
    end

    // Shared slave bus drive from the granted hold register and the data-phase owner
    always_comb begin
        HTRANS_o = HTRANS_IDLE;
        HADDR_o  = 32'h0;
        HWRITE_o = 1'b0;
        HSIZE_o  = 3'b000;
        HWDATA_o = 32'h0;
        if (grant_valid_s) begin
            HTRANS_o = HTRANS_NONSEQ;
            HADDR_o  = haddr_r[grant_id_s];
            HWRITE_o = hwrite_r[grant_id_s];
            HSIZE_o  = hsize_r[grant_id_s];
        end else begin
            HTRANS_o = HTRANS_IDLE;
        end
        if (owner_valid_r) begin
            HWDATA_o = owner_id_r ? m1_HWDATA_i : m0_HWDATA_i;
        end else begin
            HWDATA_o = 32'h0;
        end
    end

    assign m0_HREADY_o = ready_s[0];
    assign m1_HREADY_o = ready_s[1];
    assign m0_HRESP_o  = owner_valid_r & ~owner_id_r & HRESP_i;
    assign m1_HRESP_o  = owner_valid_r & owner_id_r & HRESP_i;
    assign m0_HRDATA_o = HRDATA_i;
    assign m1_HRDATA_o = HRDATA_i;

    // Master FSMs and address-phase hold registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                st_r[n]     <= ST_IDLE;
                haddr_r[n]  <= 32'h0;
                hwrite_r[n] <= 1'b0;
                hsize_r[n]  <= 3'b000;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                case (st_r[n])
                    ST_IDLE: if (capture_s[n]) st_r[n] <= ST_PEND;
                    ST_PEND: if (accept_s && (grant_id_s == 1'(n))) st_r[n] <= ST_DATA;
                    ST_DATA: if (HREADY_i) st_r[n] <= capture_s[n] ? ST_PEND : ST_IDLE;
                    default: st_r[n] <= ST_IDLE;
                endcase
                if (capture_s[n]) begin
                    haddr_r[n]  <= addr_in_s[n];
                    hwrite_r[n] <= write_in_s[n];
                    hsize_r[n]  <= size_in_s[n];
                end
            end
        end
    end

    // Grant lock, data-phase owner and m1 starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_r        <= 1'b0;
            lock_id_r     <= 1'b0;
            owner_valid_r <= 1'b0;
            owner_id_r    <= 1'b0;
            starve_r      <= '0;
        end else begin
            // A presentation the slave stalls must be held unchanged on the next cycle
            lock_r    <= grant_valid_s & ~HREADY_i;
            lock_id_r <= grant_id_s;
            if (accept_s) begin
                owner_valid_r <= 1'b1;
                owner_id_r    <= grant_id_s;
            end else if (HREADY_i) begin
                owner_valid_r <= 1'b0;
            end
            if (accept_s) begin
                if (grant_id_s) begin
                    starve_r <= '0;
                end else if ((st_r[1] == ST_PEND) && (starve_r != STARVE_MAX)) begin
                    starve_r <= starve_r + SW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_hs32_ahb_arb.sv
// Bench for hs32_ahb_arb: directed vector table, hand sequences for wait/error/reset,
// and randomized traffic checked every cycle against a transaction-level reference model.
module tb_hs32_ahb_arb;
    localparam int MS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_HADDR_i, m1_HADDR_i, m0_HWDATA_i, m1_HWDATA_i, HRDATA_i;
    logic [1:0]  m0_HTRANS_i, m1_HTRANS_i;
    logic        m0_HWRITE_i, m1_HWRITE_i, HREADY_i, HRESP_i;
    logic [2:0]  m0_HSIZE_i, m1_HSIZE_i;
    logic        m0_HREADY_o, m1_HREADY_o, m0_HRESP_o, m1_HRESP_o, HWRITE_o;
    logic [31:0] m0_HRDATA_o, m1_HRDATA_o, HADDR_o, HWDATA_o;
    logic [2:0]  HSIZE_o;
    logic [1:0]  HTRANS_o;
    logic        z_m0_HREADY_o, z_m1_HREADY_o, z_m0_HRESP_o, z_m1_HRESP_o, z_HWRITE_o;
    logic [31:0] z_m0_HRDATA_o, z_m1_HRDATA_o, z_HADDR_o, z_HWDATA_o;
    logic [2:0]  z_HSIZE_o;
    logic [1:0]  z_HTRANS_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hs32_ahb_arb #(.MAX_STARVE(MS)) dut (
        .clk(clk), .reset(reset),
        .m0_HADDR_i(m0_HADDR_i), .m0_HTRANS_i(m0_HTRANS_i), .m0_HWRITE_i(m0_HWRITE_i),
        .m0_HSIZE_i(m0_HSIZE_i), .m0_HWDATA_i(m0_HWDATA_i), .m0_HREADY_o(m0_HREADY_o),
        .m0_HRESP_o(m0_HRESP_o), .m0_HRDATA_o(m0_HRDATA_o),
        .m1_HADDR_i(m1_HADDR_i), .m1_HTRANS_i(m1_HTRANS_i), .m1_HWRITE_i(m1_HWRITE_i),
        .m1_HSIZE_i(m1_HSIZE_i), .m1_HWDATA_i(m1_HWDATA_i), .m1_HREADY_o(m1_HREADY_o),
        .m1_HRESP_o(m1_HRESP_o), .m1_HRDATA_o(m1_HRDATA_o),
        .HADDR_o(HADDR_o), .HWRITE_o(HWRITE_o), .HSIZE_o(HSIZE_o), .HTRANS_o(HTRANS_o),
        .HWDATA_o(HWDATA_o), .HREADY_i(HREADY_i), .HRESP_i(HRESP_i), .HRDATA_i(HRDATA_i)
    );

    // Second instance with MAX_STARVE=0: m1 always wins a tie.
    hs32_ahb_arb #(.MAX_STARVE(0)) dut0 (
        .clk(clk), .reset(reset),
        .m0_HADDR_i(m0_HADDR_i), .m0_HTRANS_i(m0_HTRANS_i), .m0_HWRITE_i(m0_HWRITE_i),
        .m0_HSIZE_i(m0_HSIZE_i), .m0_HWDATA_i(m0_HWDATA_i), .m0_HREADY_o(z_m0_HREADY_o),
        .m0_HRESP_o(z_m0_HRESP_o), .m0_HRDATA_o(z_m0_HRDATA_o),
        .m1_HADDR_i(m1_HADDR_i), .m1_HTRANS_i(m1_HTRANS_i), .m1_HWRITE_i(m1_HWRITE_i),
        .m1_HSIZE_i(m1_HSIZE_i), .m1_HWDATA_i(m1_HWDATA_i), .m1_HREADY_o(z_m1_HREADY_o),
        .m1_HRESP_o(z_m1_HRESP_o), .m1_HRDATA_o(z_m1_HRDATA_o),
        .HADDR_o(z_HADDR_o), .HWRITE_o(z_HWRITE_o), .HSIZE_o(z_HSIZE_o), .HTRANS_o(z_HTRANS_o),
        .HWDATA_o(z_HWDATA_o), .HREADY_i(HREADY_i), .HRESP_i(HRESP_i), .HRDATA_i(HRDATA_i)
    );

    typedef struct {
        bit          rst;
        logic [1:0]  t0, t1;
        logic [31:0] a0, a1, wd0, wd1, rdata;
        bit          w0, w1, hr, hresp;
        logic [2:0]  sz0, sz1;
    } in_t;

    typedef struct {
        in_t         in;
        bit          e_rdy0, e_rdy1;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic in_t mk(bit r0, logic [31:0] a0, bit w0, bit r1, logic [31:0] a1, bit w1, bit hr);
        in_t v;
        v.rst = 1'b0;
        v.t0 = r0 ? 2'b10 : 2'b00;  v.a0 = a0;  v.w0 = w0;  v.sz0 = 3'd2;  v.wd0 = 32'h0;
        v.t1 = r1 ? 2'b10 : 2'b00;  v.a1 = a1;  v.w1 = w1;  v.sz1 = 3'd2;  v.wd1 = 32'h0;
        v.hr = hr;  v.hresp = 1'b0;  v.rdata = 32'h0;
        return v;
    endfunction

    task automatic drive(input in_t v);
        @(negedge clk);
        reset = v.rst;
        m0_HTRANS_i = v.t0; m0_HADDR_i = v.a0; m0_HWRITE_i = v.w0; m0_HSIZE_i = v.sz0; m0_HWDATA_i = v.wd0;
        m1_HTRANS_i = v.t1; m1_HADDR_i = v.a1; m1_HWRITE_i = v.w1; m1_HSIZE_i = v.sz1; m1_HWDATA_i = v.wd1;
        HREADY_i = v.hr; HRESP_i = v.hresp; HRDATA_i = v.rdata;
        #1;
    endtask

    // Reference model: who is waiting, who owns the data phase, which grant is held.
    bit          mp [2];
    logic [31:0] ma [2];
    bit          mw [2];
    logic [2:0]  msz [2];
    int          mown = -1;
    int          mlock = -1;
    int          mst = 0;
    bit          mdl_en = 1'b0;

    function automatic int mgrant();
        if (mlock >= 0) return mlock;
        if (mp[0] && mp[1]) return (mst == MS) ? 1 : 0;
        if (mp[0]) return 0;
        if (mp[1]) return 1;
        return -1;
    endfunction

    function automatic bit mready(int n);
        if (mown == n) return HREADY_i;
        return !mp[n];
    endfunction

    function automatic bit is_req(logic [1:0] t);
        return t[1];
    endfunction

    task automatic model_step();
        int g;
        bit c0, c1;
        if (reset) begin
            mp[0] = 1'b0; mp[1] = 1'b0; mown = -1; mlock = -1; mst = 0;
        end else begin
            g  = mgrant();
            c0 = mready(0) && is_req(m0_HTRANS_i);
            c1 = mready(1) && is_req(m1_HTRANS_i);
            mlock = (g >= 0 && !HREADY_i) ? g : -1;
            if (g >= 0 && HREADY_i) begin
                if (g == 0) begin
                    if (mp[1] && mst < MS) mst = mst + 1;
                end else begin
                    mst = 0;
                end
                mp[g] = 1'b0;
                mown  = g;
            end else if (HREADY_i) begin
                mown = -1;
            end
            if (c0) begin mp[0] = 1'b1; ma[0] = m0_HADDR_i; mw[0] = m0_HWRITE_i; msz[0] = m0_HSIZE_i; end
            if (c1) begin mp[1] = 1'b1; ma[1] = m1_HADDR_i; mw[1] = m1_HWRITE_i; msz[1] = m1_HSIZE_i; end
        end
    endtask

    task automatic model_check();
        int g;
        logic [1:0]  et;
        logic [31:0] ea, ewd;
        logic        ew, r0, r1;
        logic [2:0]  es;
        g   = mgrant();
        et  = (g >= 0) ? 2'b10 : 2'b00;
        ea  = (g >= 0) ? ma[g] : 32'h0;
        ew  = (g >= 0) ? mw[g] : 1'b0;
        es  = (g >= 0) ? msz[g] : 3'b000;
        ewd = (mown == 0) ? m0_HWDATA_i : ((mown == 1) ? m1_HWDATA_i : 32'h0);
        r0  = (mown == 0) ? HRESP_i : 1'b0;
        r1  = (mown == 1) ? HRESP_i : 1'b0;
        chk("model_ctl", {m0_HREADY_o, m1_HREADY_o, m0_HRESP_o, m1_HRESP_o, HTRANS_o, HWRITE_o, HSIZE_o, HADDR_o},
            {mready(0), mready(1), r0, r1, et, ew, es, ea});
        chk("model_data", {HWDATA_o, m0_HRDATA_o, m1_HRDATA_o}, {ewd, HRDATA_i, HRDATA_i});
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) begin
        if (mdl_en) begin
            #2;
            model_check();
        end
    end

    vec_t tbl [7];
    in_t  v;
    in_t  idle;

    initial begin
        idle = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tbl[0] = '{mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1), 1'b1, 1'b1, 2'b00, 32'h0};
        tbl[1] = '{idle, 1'b0, 1'b1, 2'b10, 32'h100};
        tbl[2] = '{idle, 1'b1, 1'b1, 2'b00, 32'h0};
        tbl[2].in.rdata = 32'hCAFE;
        tbl[3] = '{mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1), 1'b1, 1'b1, 2'b00, 32'h0};
        tbl[4] = '{idle, 1'b0, 1'b0, 2'b10, 32'h10};
        tbl[5] = '{idle, 1'b1, 1'b0, 2'b10, 32'h20};
        tbl[6] = '{idle, 1'b1, 1'b1, 2'b00, 32'h0};

        reset = 1'b1;
        m0_HTRANS_i = 2'b00; m0_HADDR_i = 32'h0; m0_HWRITE_i = 1'b0; m0_HSIZE_i = 3'b0; m0_HWDATA_i = 32'h0;
        m1_HTRANS_i = 2'b00; m1_HADDR_i = 32'h0; m1_HWRITE_i = 1'b0; m1_HSIZE_i = 3'b0; m1_HWDATA_i = 32'h0;
        HREADY_i = 1'b1; HRESP_i = 1'b0; HRDATA_i = 32'h0;
        @(posedge clk);
        mdl_en = 1'b1;
        v = idle; v.rst = 1'b1;
        drive(v);
        chk("rst_master", {m0_HREADY_o, m1_HREADY_o, m0_HRESP_o, m1_HRESP_o}, 4'b1100);
        chk("rst_bus", {HTRANS_o, HWRITE_o, HSIZE_o, HADDR_o, HWDATA_o}, 70'h0);

        // Tie resolution in both instances, plus starve counter step and clear
        drive(mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1));
        drive(idle);
        chk("tie_m0_wins", HADDR_o, 32'h10);
        chk("tie_forced_m1", z_HADDR_o, 32'h20);
        drive(idle);
        chk("tie_m1_next", HADDR_o, 32'h20);
        chk("tie_forced_m0_next", z_HADDR_o, 32'h10);
        chk("starve_step", dut.starve_r, 3'd1);
        drive(idle);
        chk("starve_clear", dut.starve_r, 3'd0);
        drive(idle);

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].in);
            chk($sformatf("vec%0d", i), {m0_HREADY_o, m1_HREADY_o, HTRANS_o, HADDR_o, m0_HRDATA_o},
                {tbl[i].e_rdy0, tbl[i].e_rdy1, tbl[i].e_trans, tbl[i].e_addr, tbl[i].in.rdata});
        end

        // Wait-state hold on an m1 presentation while m0 requests
        drive(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h30, 1'b0, 1'b1));
        drive(mk(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        chk("wait_first", {HTRANS_o, HADDR_o, m1_HREADY_o}, {2'b10, 32'h30, 1'b0});
        for (int k = 0; k < 2; k++) begin
            drive(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
            chk("wait_hold", {HTRANS_o, HADDR_o, m0_HREADY_o, m1_HREADY_o}, {2'b10, 32'h30, 1'b0, 1'b0});
        end
        drive(idle);
        chk("wait_release", {HTRANS_o, HADDR_o}, {2'b10, 32'h30});
        drive(idle);
        chk("wait_next_m0", {HADDR_o, m1_HREADY_o}, {32'h50, 1'b1});
        drive(idle);
        drive(idle);

        // Write to 0x40 answered with a two-cycle ERROR, then a follow-up read
        drive(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1));
        drive(idle);
        chk("err_addr", {HTRANS_o, HWRITE_o, HADDR_o}, {2'b10, 1'b1, 32'h40});
        v = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); v.hresp = 1'b1; v.wd1 = 32'hDEAD;
        drive(v);
        chk("err_cycle1", {HWDATA_o, m1_HRESP_o, m0_HRESP_o, m1_HREADY_o}, {32'hDEAD, 1'b1, 1'b0, 1'b0});
        v = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b1); v.hresp = 1'b1; v.wd1 = 32'hDEAD;
        drive(v);
        chk("err_cycle2", {HWDATA_o, m1_HRESP_o, m0_HRESP_o, m1_HREADY_o}, {32'hDEAD, 1'b1, 1'b0, 1'b1});
        drive(idle);
        chk("err_follow", {HADDR_o, HWRITE_o, m1_HRESP_o, HWDATA_o}, {32'h44, 1'b0, 1'b0, 32'h0});
        drive(idle);
        drive(idle);

        // Reset with m0 in its data phase and m1 pending
        drive(mk(1'b1, 32'h60, 1'b0, 1'b1, 32'h70, 1'b0, 1'b1));
        drive(idle);
        v = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); v.rst = 1'b1;
        drive(v);
        chk("pre_rst_addr", {HADDR_o, m0_HREADY_o, m1_HREADY_o}, {32'h70, 1'b0, 1'b0});
        chk("pre_rst_starve", dut.starve_r, 3'd1);
        drive(idle);
        chk("post_rst_out", {m0_HREADY_o, m1_HREADY_o, HTRANS_o, HADDR_o, HWDATA_o}, {1'b1, 1'b1, 2'b00, 64'h0});
        chk("post_rst_starve", dut.starve_r, 3'd0);
        drive(idle);

        for (int c = 0; c < 800; c++) begin
            v.rst   = ($urandom_range(0, 99) == 0);
            v.t0    = 2'($urandom_range(0, 3));
            v.t1    = 2'($urandom_range(0, 3));
            v.a0    = $urandom;
            v.a1    = $urandom;
            v.w0    = 1'($urandom_range(0, 1));
            v.w1    = 1'($urandom_range(0, 1));
            v.sz0   = 3'($urandom_range(0, 7));
            v.sz1   = 3'($urandom_range(0, 7));
            v.wd0   = $urandom;
            v.wd1   = $urandom;
            v.hr    = ($urandom_range(0, 3) != 0);
            v.hresp = ($urandom_range(0, 7) == 0);
            v.rdata = $urandom;
            drive(v);
        end
        drive(idle);
        drive(idle);
        mdl_en = 1'b0;
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
